branch_compare_unit: RTL



---
 rtl/branch_compare_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator: compares A/B one CHUNK-bit slice per cycle, MSB slice first.
// Define BRCMP_EARLY_EXIT_EN to finish on the first differing slice instead of after all slices.
module branch_compare_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            BrEq,
  output logic            BrLt,
  output logic            taken,
  output logic            illegal
);

  localparam int unsigned NChunk = XLEN / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NChunk - 1);

  if ((XLEN % CHUNK) != 0) begin : gen_bad_chunk
    $error("branch_compare_unit: XLEN must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e          state;
  logic [XLEN-1:0] aReg;
  logic [XLEN-1:0] bReg;
  logic [2:0]      f3Reg;
  logic [IdxW-1:0] idx;
  logic            eqAcc;
  logic            ltAcc;

  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic             sliceDiff;
  logic             sliceLt;
  logic             eqNext;
  logic             ltNext;
  logic             cmpDone;
  logic             illegalNext;
  logic             takenNext;

  assign in_ready = (state == StIdle) && !rst;

  always_comb begin
    sliceA = aReg[int'(idx) * CHUNK +: CHUNK];
    sliceB = bReg[int'(idx) * CHUNK +: CHUNK];
    // Flipping the sign bits turns a signed compare into an unsigned one.
    if ((idx == TopIdx) && !f3Reg[1]) begin
      sliceA[CHUNK-1] = ~sliceA[CHUNK-1];
      sliceB[CHUNK-1] = ~sliceB[CHUNK-1];
    end
    sliceDiff = (sliceA != sliceB);
    sliceLt   = (sliceA < sliceB);
    eqNext    = eqAcc && !sliceDiff;
    ltNext    = (eqAcc && sliceDiff) ? sliceLt : ltAcc;
`ifdef BRCMP_EARLY_EXIT_EN
    cmpDone   = (idx == '0) || (eqAcc && sliceDiff);
`else
    cmpDone   = (idx == '0);
`endif
    illegalNext = (f3Reg[2:1] == 2'b01);
    case (f3Reg)
      3'b000:         takenNext = eqNext;
      3'b001:         takenNext = !eqNext;
      3'b100, 3'b110: takenNext = ltNext;
      3'b101, 3'b111: takenNext = !ltNext;
      default:        takenNext = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      aReg      <= '0;
      bReg      <= '0;
      f3Reg     <= '0;
      idx       <= '0;
      eqAcc     <= 1'b0;
      ltAcc     <= 1'b0;
      out_valid <= 1'b0;
      BrEq      <= 1'b0;
      BrLt      <= 1'b0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            aReg  <= A;
            bReg  <= B;
            f3Reg <= funct3;
            idx   <= TopIdx;
            eqAcc <= 1'b1;
            ltAcc <= 1'b0;
            state <= StCmp;
          end
        end
        StCmp: begin
          eqAcc <= eqNext;
          ltAcc <= ltNext;
          if (cmpDone) begin
            state     <= StDone;
            out_valid <= 1'b1;
            BrEq      <= eqNext;
            BrLt      <= ltNext;
            illegal   <= illegalNext;
            taken     <= takenNext;
          end else begin
            idx <= idx - IdxW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
